vme_ram_readout: RTL

//  Downstream of the VME RAM write-address generator. Detects end of a 1024-word capture
//  (falling edge of the writer's wr_ena), then drains the RAM read port word-by-word
//  on single-word VME read requests. Holds off new triggers until the buffer is drained
//  or cleared. Sits between the capture RAM read port and the VME slave register decoder.

---
 rtl/vme_rdo_pkg.sv | 17 +
 rtl/vme_rdo_hdr_fmt.sv | 15 +
 rtl/vme_ram_readout.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/vme_rdo_pkg.sv
// Shared types and constants for the VME capture-RAM readout block.
package vme_rdo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_FETCH = 3'd2,
    ST_WAIT  = 3'd3,
    ST_ACK   = 3'd4,
    ST_DONE  = 3'd5
  } rdo_state_t;

  localparam logic [7:0]  HDR_MAGIC = 8'hA5;
  localparam int unsigned EVT_CNT_W = 16;
  localparam int unsigned LAT_W     = 2;

endpackage : vme_rdo_pkg

// File: rtl/vme_rdo_hdr_fmt.sv
// Combinational readout header packer: {magic, event count, address width},
// zero-extended to the data width.
module vme_rdo_hdr_fmt
  import vme_rdo_pkg::*;
#(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
) (
  input  logic [EVT_CNT_W-1:0] evt_cnt_i,
  output logic [DW-1:0]        hdr_word_c_o
);

  assign hdr_word_c_o = DW'({HDR_MAGIC, evt_cnt_i, 8'(AW)});

endmodule : vme_rdo_hdr_fmt

// File: rtl/vme_ram_readout.sv
// Drains a completed 2**AW-word capture buffer one word per VME read request.
// Optional readout header word enabled by defining VME_RDO_HEADER_EN.
module vme_ram_readout
  import vme_rdo_pkg::*;
#(
  parameter int unsigned AW     = 10,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_ena_i,
  output logic                 ram_rd_en_o,
  output logic [AW-1:0]        ram_rd_addr_o,
  input  logic [DW-1:0]        ram_rd_data_i,
  input  logic                 vme_rd_req_i,
  output logic [DW-1:0]        vme_rd_data_o,
  output logic                 vme_rd_ack_o,
  input  logic                 vme_clear_i,
  output logic                 buf_ready_o,
  output logic                 rdo_done_o,
  output logic                 trig_inhibit_o,
  output logic [EVT_CNT_W-1:0] evt_cnt_o,
  output logic                 ovr_flag_o
);

  localparam logic [AW-1:0]    ADDR_LAST = {AW{1'b1}};
  localparam logic [LAT_W-1:0] LAT_LOAD  = LAT_W'(RD_LAT - 1);

  rdo_state_t           state_q, state_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [LAT_W-1:0]     lat_q, lat_d;
  logic                 wr_ena_q;
  logic                 ram_rd_en_q, ram_rd_en_d;
  logic [DW-1:0]        rd_data_q, rd_data_d;
  logic                 ack_q, ack_d;
  logic                 buf_ready_q, buf_ready_d;
  logic                 rdo_done_q, rdo_done_d;
  logic                 inhibit_q, inhibit_d;
  logic [EVT_CNT_W-1:0] evt_cnt_q, evt_cnt_d;
  logic                 ovr_q, ovr_d;
  logic                 hdr_pend_q, hdr_pend_d;
  logic [DW-1:0]        hdr_word;
  logic                 capture_edge;

`ifdef VME_RDO_HEADER_EN
  localparam logic HDR_EN = 1'b1;

  vme_rdo_hdr_fmt #(
    .AW (AW),
    .DW (DW)
  ) u_hdr_fmt (
    .evt_cnt_i    (evt_cnt_q),
    .hdr_word_c_o (hdr_word)
  );
`else
  localparam logic HDR_EN = 1'b0;

  assign hdr_word = '0;
`endif

  // Writer finished its capture when its write enable drops.
  assign capture_edge = wr_ena_q & ~wr_ena_i;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      lat_q       <= '0;
      wr_ena_q    <= 1'b0;
      ram_rd_en_q <= 1'b0;
      rd_data_q   <= '0;
      ack_q       <= 1'b0;
      buf_ready_q <= 1'b0;
      rdo_done_q  <= 1'b0;
      inhibit_q   <= 1'b0;
      evt_cnt_q   <= '0;
      ovr_q       <= 1'b0;
      hdr_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      lat_q       <= lat_d;
      wr_ena_q    <= wr_ena_i;
      ram_rd_en_q <= ram_rd_en_d;
      rd_data_q   <= rd_data_d;
      ack_q       <= ack_d;
      buf_ready_q <= buf_ready_d;
      rdo_done_q  <= rdo_done_d;
      inhibit_q   <= inhibit_d;
      evt_cnt_q   <= evt_cnt_d;
      ovr_q       <= ovr_d;
      hdr_pend_q  <= hdr_pend_d;
    end
  end

  // Next-state and registered-output logic; clear overrides every other event.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    lat_d       = lat_q;
    ram_rd_en_d = 1'b0;
    rd_data_d   = rd_data_q;
    ack_d       = 1'b0;
    buf_ready_d = buf_ready_q;
    rdo_done_d  = 1'b0;
    evt_cnt_d   = evt_cnt_q;
    ovr_d       = ovr_q;
    hdr_pend_d  = hdr_pend_q;

    if (vme_clear_i) begin
      state_d     = ST_IDLE;
      addr_d      = '0;
      buf_ready_d = 1'b0;
      ovr_d       = 1'b0;
      hdr_pend_d  = 1'b0;
    end else begin
      if (capture_edge && (state_q != ST_IDLE)) begin
        ovr_d = 1'b1;
      end
      if (vme_rd_req_i && (state_q != ST_READY)) begin
        ovr_d = 1'b1;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (capture_edge) begin
            state_d     = ST_READY;
            addr_d      = '0;
            evt_cnt_d   = evt_cnt_q + EVT_CNT_W'(1);
            buf_ready_d = 1'b1;
            hdr_pend_d  = HDR_EN;
          end
        end
        ST_READY: begin
          if (vme_rd_req_i) begin
            state_d     = ST_FETCH;
            ram_rd_en_d = ~hdr_pend_q;
          end
        end
        ST_FETCH: begin
          if (hdr_pend_q) begin
            state_d   = ST_ACK;
            rd_data_d = hdr_word;
            ack_d     = 1'b1;
          end else begin
            state_d = ST_WAIT;
            lat_d   = LAT_LOAD;
          end
        end
        ST_WAIT: begin
          if (lat_q == '0) begin
            state_d   = ST_ACK;
            rd_data_d = ram_rd_data_i;
            ack_d     = 1'b1;
          end else begin
            lat_d = lat_q - LAT_W'(1);
          end
        end
        ST_ACK: begin
          if (hdr_pend_q) begin
            state_d    = ST_READY;
            hdr_pend_d = 1'b0;
          end else if (addr_q == ADDR_LAST) begin
            state_d     = ST_DONE;
            addr_d      = '0;
            buf_ready_d = 1'b0;
            rdo_done_d  = 1'b1;
          end else begin
            state_d = ST_READY;
            addr_d  = addr_q + AW'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    inhibit_d = (state_d != ST_IDLE);
  end

  assign ram_rd_en_o    = ram_rd_en_q;
  assign ram_rd_addr_o  = addr_q;
  assign vme_rd_data_o  = rd_data_q;
  assign vme_rd_ack_o   = ack_q;
  assign buf_ready_o    = buf_ready_q;
  assign rdo_done_o     = rdo_done_q;
  assign trig_inhibit_o = inhibit_q;
  assign evt_cnt_o      = evt_cnt_q;
  assign ovr_flag_o     = ovr_q;

endmodule : vme_ram_readout
